ibuf_skew_pp: RTL and testbench

IBUF_SKEW_PP -- requirements
Module: ibuf_skew_pp

---
 rtl/ibuf_skew_pp_pkg.sv | 23 ++
 rtl/ibuf_lane_bank.sv | 39 +++
 rtl/ibuf_skew_pp.sv | 140 ++++++++++++++
 tb/tb_ibuf_skew_pp.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_skew_pp_pkg.sv
// Shared definitions for the skewed ping-pong input buffer.
// Holds the default geometry (lane count, element width, depth, tag width),
// the drain-state encoding and a helper that sizes the drain counter.
package ibuf_skew_pp_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_TW    = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    // Drain counter must reach N+DEPTH-2; never narrower than 5 bits.
    function automatic int cnt_width(input int n, input int depth);
        int w;
        w = $clog2(n + depth);
        cnt_width = (w < 5) ? 5 : w;
    endfunction

endpackage

// File: rtl/ibuf_lane_bank.sv
// One lane of the input buffer: two banks of DEPTH elements each.
// Ports:
//   clk_i    - clock (storage is intentionally not reset)
//   we_i     - write the whole lane word into bank wbank_i
//   wbank_i  - bank selected for writing
//   wdata_i  - lane word, element j at [j*DW +: DW]
//   rbank_i  - bank selected for reading
//   ridx_i   - element index to read
//   rdata_o  - selected element
module ibuf_lane_bank
    import ibuf_skew_pp_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = 2
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  wbank_i,
    input  logic [DEPTH*DW-1:0]   wdata_i,
    input  logic                  rbank_i,
    input  logic [IW-1:0]         ridx_i,
    output logic [DW-1:0]         rdata_o
);

    logic [DEPTH*DW-1:0] bank_q [2];
    logic [DEPTH*DW-1:0] rword_s;

    // Lane word storage; a rewrite simply overwrites.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            bank_q[wbank_i] <= wdata_i;
        end
    end

    assign rword_s = bank_q[rbank_i];
    assign rdata_o = rword_s[ridx_i*DW +: DW];

endmodule

// File: rtl/ibuf_skew_pp.sv
// Skewed ping-pong input buffer feeding N array rows.
// One bank is filled lane-by-lane while the other is drained diagonally:
// in drain cycle c, lane k presents element c-k (zero outside its window).
// Ports:
//   CLK, RSTN              - clock, async active-low reset
//   LOAD_EN/IDST/IWord     - write one lane word into the fill bank
//   LOAD_DONE, LOAD_RDY    - commit fill bank / fill bank available
//   START_CALC, ODST_i     - request drain of committed tile with a tag
//   IROW_o, ICOL_VALID     - skewed row (lane 0 in MSBs) and per-lane valid
//   ODST_o                 - tag of the tile being drained (held afterwards)
//   CALC_BUSY, DRAIN_DONE  - drain active / last drain cycle
//   START_ERR              - pulse after a rejected START_CALC
module ibuf_skew_pp
    import ibuf_skew_pp_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TW    = DEF_TW,
    localparam int AW   = (N > 1) ? $clog2(N) : 1,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = cnt_width(N, DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 LOAD_EN,
    input  logic [AW-1:0]        IDST,
    input  logic [DEPTH*DW-1:0]  IWord,
    input  logic                 LOAD_DONE,
    output logic                 LOAD_RDY,
    input  logic                 START_CALC,
    input  logic [TW-1:0]        ODST_i,
    output logic [N*DW-1:0]      IROW_o,
    output logic [N-1:0]         ICOL_VALID,
    output logic [TW-1:0]        ODST_o,
    output logic                 CALC_BUSY,
    output logic                 DRAIN_DONE,
    output logic                 START_ERR
);

    localparam logic [CW-1:0] C_LAST = CW'(N + DEPTH - 2);

    drain_state_e    state_q;
    logic [CW-1:0]   c_q;
    logic [1:0]      bank_full_q;
    logic            fill_sel_q;
    logic            drain_sel_q;
    logic [TW-1:0]   odst_q;
    logic            err_q;

    logic            load_rdy_s;
    logic            busy_s;
    logic            last_s;

    assign load_rdy_s = ~bank_full_q[fill_sel_q];
    assign busy_s     = (state_q == ST_DRAIN);
    assign last_s     = busy_s && (c_q == C_LAST);

    // Bank bookkeeping, drain FSM, tag capture and start-error pulse.
    // Commit targets fill_sel and free targets drain_sel; they can never be
    // the same bank in one cycle because a full fill bank blocks commits.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            c_q         <= {CW{1'b0}};
            bank_full_q <= 2'b00;
            fill_sel_q  <= 1'b0;
            drain_sel_q <= 1'b0;
            odst_q      <= {TW{1'b0}};
            err_q       <= 1'b0;
        end else begin
            err_q <= START_CALC & (busy_s | ~bank_full_q[drain_sel_q]);

            if (LOAD_DONE && load_rdy_s) begin
                bank_full_q[fill_sel_q] <= 1'b1;
                fill_sel_q              <= ~fill_sel_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (START_CALC && bank_full_q[drain_sel_q]) begin
                        state_q <= ST_DRAIN;
                        c_q     <= {CW{1'b0}};
                        odst_q  <= ODST_i;
                    end
                end
                ST_DRAIN: begin
                    if (c_q == C_LAST) begin
                        state_q                  <= ST_IDLE;
                        c_q                      <= {CW{1'b0}};
                        bank_full_q[drain_sel_q] <= 1'b0;
                        drain_sel_q              <= ~drain_sel_q;
                    end else begin
                        c_q <= c_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    c_q     <= {CW{1'b0}};
                end
            endcase
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic          we_s;
        logic [CW:0]   rel_s;
        logic          valid_s;
        logic [DW-1:0] rd_s;

        assign we_s = LOAD_EN & load_rdy_s & (IDST == AW'(k));
        // rel = c - k with a borrow bit: negative means lane not yet started.
        assign rel_s   = {1'b0, c_q} - (CW+1)'(k);
        assign valid_s = busy_s & ~rel_s[CW] & (rel_s[CW-1:0] < CW'(DEPTH));

        ibuf_lane_bank #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .IW    (IW)
        ) u_bank (
            .clk_i   (CLK),
            .we_i    (we_s),
            .wbank_i (fill_sel_q),
            .wdata_i (IWord),
            .rbank_i (drain_sel_q),
            .ridx_i  (IW'(rel_s)),
            .rdata_o (rd_s)
        );

        assign IROW_o[(N-1-k)*DW +: DW] = valid_s ? rd_s : {DW{1'b0}};
        assign ICOL_VALID[k]            = valid_s;
    end

    assign LOAD_RDY   = load_rdy_s;
    assign ODST_o     = odst_q;
    assign CALC_BUSY  = busy_s;
    assign DRAIN_DONE = last_s;
    assign START_ERR  = err_q;

endmodule

// File: tb/tb_ibuf_skew_pp.sv
// Directed self-checking bench for ibuf_skew_pp (N=4, DW=8, DEPTH=4, TW=4).
module tb_ibuf_skew_pp;

    localparam int N = 4, DW = 8, DEPTH = 4, TW = 4;

    logic                CLK, RSTN, LOAD_EN, LOAD_DONE, START_CALC;
    logic [1:0]          IDST;
    logic [DEPTH*DW-1:0] IWord;
    logic [TW-1:0]       ODST_i;
    logic                LOAD_RDY, CALC_BUSY, DRAIN_DONE, START_ERR;
    logic [N*DW-1:0]     IROW_o;
    logic [N-1:0]        ICOL_VALID;
    logic [TW-1:0]       ODST_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_row_a [7] = '{32'h00000000, 32'h01100000, 32'h02112000,
                                   32'h03122130, 32'h00132231, 32'h00002332,
                                   32'h00000033};
    logic [3:0]  exp_vld   [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                   4'b1110, 4'b1100, 4'b1000};

    ibuf_skew_pp #(.N(N), .DW(DW), .DEPTH(DEPTH), .TW(TW)) dut (
        .CLK(CLK), .RSTN(RSTN), .LOAD_EN(LOAD_EN), .IDST(IDST), .IWord(IWord),
        .LOAD_DONE(LOAD_DONE), .LOAD_RDY(LOAD_RDY), .START_CALC(START_CALC),
        .ODST_i(ODST_i), .IROW_o(IROW_o), .ICOL_VALID(ICOL_VALID),
        .ODST_o(ODST_o), .CALC_BUSY(CALC_BUSY), .DRAIN_DONE(DRAIN_DONE),
        .START_ERR(START_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] pat(input logic [31:0] base, input int k);
        return base + 32'h10101010 * k;
    endfunction

    task automatic write_lane(input int k, input logic [31:0] w);
        LOAD_EN = 1'b1; IDST = 2'(k); IWord = w;
        tick();
        LOAD_EN = 1'b0;
    endtask

    task automatic load_tile(input logic [31:0] base);
        for (int k = 0; k < N; k++) write_lane(k, pat(base, k));
        LOAD_DONE = 1'b1;
        tick();
        LOAD_DONE = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] tag);
        START_CALC = 1'b1; ODST_i = tag;
        tick();
        START_CALC = 1'b0; ODST_i = 4'hF;
    endtask

    task automatic test_reset();
        checks++;
        if ({LOAD_RDY, CALC_BUSY, DRAIN_DONE, START_ERR} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 1000",
                     {LOAD_RDY, CALC_BUSY, DRAIN_DONE, START_ERR});
        end
        checks++;
        if ({IROW_o, ICOL_VALID, ODST_o} !== 40'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {IROW_o, ICOL_VALID, ODST_o});
        end
    endtask

    task automatic test_basic_drain();
        load_tile(32'h03020100);
        do_start(4'h5);
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (IROW_o !== exp_row_a[c]) begin
                errors++;
                $display("FAIL basic_row c=%0d: got %h expected %h", c, IROW_o, exp_row_a[c]);
            end
            checks++;
            if (ICOL_VALID !== exp_vld[c]) begin
                errors++;
                $display("FAIL basic_valid c=%0d: got %b expected %b", c, ICOL_VALID, exp_vld[c]);
            end
            checks++;
            if ({CALC_BUSY, DRAIN_DONE} !== {1'b1, (c == 6)}) begin
                errors++;
                $display("FAIL basic_busy_done c=%0d: got %b expected %b",
                         c, {CALC_BUSY, DRAIN_DONE}, {1'b1, (c == 6)});
            end
            checks++;
            if (ODST_o !== 4'h5) begin
                errors++;
                $display("FAIL basic_tag c=%0d: got %h expected 5", c, ODST_o);
            end
            tick();
        end
        checks++;
        if ({CALC_BUSY, DRAIN_DONE, ICOL_VALID, IROW_o} !== 38'h0) begin
            errors++;
            $display("FAIL basic_idle_after: got %h expected 0",
                     {CALC_BUSY, DRAIN_DONE, ICOL_VALID, IROW_o});
        end
    endtask

    task automatic test_back_to_back();
        load_tile(32'h03020100);
        do_start(4'h1);
        for (int c = 0; c < 7; c++) begin
            if (c <= 4) begin
                checks++;
                if (LOAD_RDY !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_load_rdy c=%0d: got %b expected 1", c, LOAD_RDY);
                end
            end
            if (c == 3) begin
                checks++;
                if (IROW_o !== 32'h03122130) begin
                    errors++;
                    $display("FAIL b2b_a_row: got %h expected 03122130", IROW_o);
                end
            end
            if (c == 6) begin
                checks++;
                if (DRAIN_DONE !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_a_done: got %b expected 1", DRAIN_DONE);
                end
            end
            if (c < 4) begin
                LOAD_EN = 1'b1; IDST = 2'(c); IWord = pat(32'h83828180, c);
            end else if (c == 4) begin
                LOAD_DONE = 1'b1;
            end
            tick();
            LOAD_EN = 1'b0; LOAD_DONE = 1'b0;
        end
        checks++;
        if ({CALC_BUSY, LOAD_RDY} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gap: got busy,rdy=%b expected 01", {CALC_BUSY, LOAD_RDY});
        end
        do_start(4'h2);
        checks++;
        if ({IROW_o, ICOL_VALID, ODST_o} !== {32'h80000000, 4'b0001, 4'h2}) begin
            errors++;
            $display("FAIL b2b_b_c0: got %h expected 80000000_1_2", {IROW_o, ICOL_VALID, ODST_o});
        end
        tick(); tick(); tick();
        checks++;
        if (IROW_o !== 32'h8392A1B0) begin
            errors++;
            $display("FAIL b2b_b_c3: got %h expected 8392a1b0", IROW_o);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (CALC_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_b_end: got busy %b expected 0", CALC_BUSY);
        end
    endtask

    task automatic test_both_full();
        load_tile(32'h03020100);
        load_tile(32'h43424140);
        checks++;
        if (LOAD_RDY !== 1'b0) begin
            errors++;
            $display("FAIL full_rdy: got %b expected 0", LOAD_RDY);
        end
        write_lane(0, 32'hDEADBEEF);
        do_start(4'h3);
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (LOAD_RDY !== 1'b0) begin
                errors++;
                $display("FAIL full_rdy_drain c=%0d: got %b expected 0", c, LOAD_RDY);
            end
            tick();
        end
        checks++;
        if (LOAD_RDY !== 1'b1) begin
            errors++;
            $display("FAIL full_rdy_freed: got %b expected 1", LOAD_RDY);
        end
        do_start(4'h4);
        checks++;
        if (IROW_o !== 32'h40000000) begin
            errors++;
            $display("FAIL full_d_c0: got %h expected 40000000", IROW_o);
        end
        tick(); tick(); tick();
        checks++;
        if (IROW_o !== 32'h43526170) begin
            errors++;
            $display("FAIL full_d_c3: got %h expected 43526170", IROW_o);
        end
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_start_err();
        START_CALC = 1'b1;
        tick();
        START_CALC = 1'b0;
        checks++;
        if ({START_ERR, CALC_BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL err_empty: got err,busy=%b expected 10", {START_ERR, CALC_BUSY});
        end
        tick();
        checks++;
        if (START_ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_len: got %b expected 0", START_ERR);
        end
        load_tile(32'h03020100);
        do_start(4'h6);
        tick();
        START_CALC = 1'b1; ODST_i = 4'hC;
        tick();
        START_CALC = 1'b0;
        checks++;
        if ({START_ERR, ODST_o, IROW_o, ICOL_VALID} !== {1'b1, 4'h6, 32'h02112000, 4'b0111}) begin
            errors++;
            $display("FAIL err_middrain: got %h expected 1_6_02112000_7",
                     {START_ERR, ODST_o, IROW_o, ICOL_VALID});
        end
        tick(); tick(); tick(); tick();
        checks++;
        if ({START_ERR, DRAIN_DONE, IROW_o} !== {1'b0, 1'b1, 32'h00000033}) begin
            errors++;
            $display("FAIL err_drain_end: got %h expected 0_1_00000033",
                     {START_ERR, DRAIN_DONE, IROW_o});
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        load_tile(32'h03020100);
        load_tile(32'h43424140);
        do_start(4'h7);
        tick(); tick();
        RSTN = 1'b0;
        #1;
        checks++;
        if ({IROW_o, ICOL_VALID, ODST_o, CALC_BUSY, DRAIN_DONE, START_ERR, LOAD_RDY}
                !== {32'h0, 4'h0, 4'h0, 4'b0001}) begin
            errors++;
            $display("FAIL rst_mid: got %h expected 00000000_0_0_1",
                     {IROW_o, ICOL_VALID, ODST_o, CALC_BUSY, DRAIN_DONE, START_ERR, LOAD_RDY});
        end
        @(negedge CLK);
        RSTN = 1'b1;
        tick();
        START_CALC = 1'b1;
        tick();
        START_CALC = 1'b0;
        checks++;
        if ({START_ERR, CALC_BUSY, LOAD_RDY} !== 3'b101) begin
            errors++;
            $display("FAIL rst_then_start: got %b expected 101", {START_ERR, CALC_BUSY, LOAD_RDY});
        end
        tick();
    endtask

    task automatic test_write_with_commit();
        for (int k = 0; k < 3; k++) write_lane(k, pat(32'h03020100, k));
        LOAD_EN = 1'b1; IDST = 2'd3; IWord = 32'h77665544; LOAD_DONE = 1'b1;
        tick();
        LOAD_EN = 1'b0; LOAD_DONE = 1'b0;
        do_start(4'hA);
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (ODST_o !== 4'hA) begin
                errors++;
                $display("FAIL same_tag c=%0d: got %h expected a", c, ODST_o);
            end
            if (c == 3) begin
                checks++;
                if (IROW_o !== 32'h03122144) begin
                    errors++;
                    $display("FAIL same_row_c3: got %h expected 03122144", IROW_o);
                end
            end
            if (c == 6) begin
                checks++;
                if (IROW_o !== 32'h00000077) begin
                    errors++;
                    $display("FAIL same_row_c6: got %h expected 00000077", IROW_o);
                end
            end
            tick();
        end
        checks++;
        if (ODST_o !== 4'hA) begin
            errors++;
            $display("FAIL same_tag_hold: got %h expected a", ODST_o);
        end
    endtask

    initial begin
        RSTN = 1'b0; LOAD_EN = 1'b0; LOAD_DONE = 1'b0; START_CALC = 1'b0;
        IDST = 2'd0; IWord = 32'h0; ODST_i = 4'h0;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        tick();
        test_reset();
        test_basic_drain();
        test_back_to_back();
        test_both_full();
        test_start_err();
        test_reset_mid_drain();
        test_write_with_commit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
